// File: rtl/barrel_shifter_32.sv
// Registered logarithmic barrel shifter: LSL, LSR, ASR and rotate left/right.
// One mux stage per shift_amt bit; result and out_valid land one cycle after in_valid.

module bs_stage #(
  parameter int WIDTH = 32,
  parameter int AMT   = 1
) (
  input  logic             en,
  input  logic             left,
  input  logic             rot,
  input  logic             fill,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = a;
    if (en) begin
      if (left) y = {a[WIDTH-AMT-1:0], rot ? a[WIDTH-1:WIDTH-AMT] : {AMT{1'b0}}};
      else      y = {rot ? a[AMT-1:0] : {AMT{fill}}, a[WIDTH-1:AMT]};
    end
  end
endmodule

module barrel_shifter_32 #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         d,
  input  logic [$clog2(WIDTH)-1:0] shift_amt,
  input  logic [1:0]               op,
  input  logic                     dir,
  output logic [WIDTH-1:0]         q,
  output logic                     out_valid
);
  localparam int SW = $clog2(WIDTH);

  logic left, rot, fill;
  logic [SW:0][WIDTH-1:0] stage_d;

  // ASR keeps the original sign bit in place, so every stage can fill from d's MSB.
  assign left       = (op == 2'b00) || (op == 2'b11 && !dir);
  assign rot        = (op == 2'b11);
  assign fill       = (op == 2'b10) && d[WIDTH-1];
  assign stage_d[0] = d;

  for (genvar i = 0; i < SW; i++) begin : g_stage
    bs_stage #(.WIDTH(WIDTH), .AMT(1 << i)) u_stage (
      .en   (shift_amt[i]),
      .left (left),
      .rot  (rot),
      .fill (fill),
      .a    (stage_d[i]),
      .y    (stage_d[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) q <= stage_d[SW];
    end
  end
endmodule

// File: tb/tb_barrel_shifter_32.sv
// Scoreboard bench for barrel_shifter_32: directed vectors, hold/reset cases and
// back-to-back random traffic checked by a negedge monitor.

module tb_barrel_shifter_32;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] d;
  logic [4:0]  shift_amt;
  logic [1:0]  op;
  logic        dir;
  logic [31:0] q;
  logic        out_valid;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  barrel_shifter_32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .d         (d),
    .shift_amt (shift_amt),
    .op        (op),
    .dir       (dir),
    .q         (q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [4:0] n,
                                            input logic [1:0] o, input logic r);
    logic [31:0] res;
    case (o)
      2'b00:   res = a << n;
      2'b01:   res = a >> n;
      2'b10:   res = $unsigned($signed(a) >>> n);
      default: begin
        if (n == 0)  res = a;
        else if (!r) res = (a << n) | (a >> (6'd32 - {1'b0, n}));
        else         res = (a >> n) | (a << (6'd32 - {1'b0, n}));
      end
    endcase
    return res;
  endfunction

  // Inputs change 1 time unit after a rising edge and are captured at the next one.
  task automatic issue(input logic [31:0] a, input logic [4:0] n, input logic [1:0] o,
                       input logic r, input logic [31:0] exp);
    in_valid = 1'b1; d = a; shift_amt = n; op = o; dir = r;
    exp_q.push_back(exp);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; d = $urandom; shift_amt = 5'($urandom); op = 2'($urandom); dir = 1'($urandom);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_out_valid: got q=%h with nothing expected", q);
      end else begin
        check("q", q, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [4:0]  n;
    logic [1:0]  o;
    logic        r;

    rst_n = 1'b0; in_valid = 1'b1; d = 32'hFFFF_FFFF; shift_amt = 5'd3; op = 2'b00; dir = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_q", q, 32'h0);
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    rst_n = 1'b1;

    issue(32'h0000_0001, 5'd1,  2'b00, 1'b0, 32'h0000_0002);
    issue(32'h8000_0000, 5'd4,  2'b01, 1'b0, 32'h0800_0000);
    issue(32'hF000_0000, 5'd3,  2'b10, 1'b0, 32'hFE00_0000);
    issue(32'h1234_5678, 5'd8,  2'b11, 1'b0, 32'h3456_7812);
    issue(32'h8765_4321, 5'd8,  2'b11, 1'b1, 32'h2187_6543);
    for (int k = 0; k < 8; k++)
      issue(32'hA5A5_A5A5, 5'd0, 2'(k >> 1), 1'(k), 32'hA5A5_A5A5);
    issue(32'h8000_0001, 5'd31, 2'b11, 1'b0, 32'hC000_0000);
    issue(32'h8000_0001, 5'd31, 2'b11, 1'b1, 32'h0000_0003);
    issue(32'h8000_0000, 5'd31, 2'b10, 1'b0, 32'hFFFF_FFFF);
    issue(32'h7FFF_FFFF, 5'd31, 2'b10, 1'b1, 32'h0000_0000);
    issue(32'hFFFF_FFFF, 5'd31, 2'b01, 1'b1, 32'h0000_0001);
    issue(32'h0000_0003, 5'd31, 2'b00, 1'b1, 32'h8000_0000);
    issue(32'h0000_0001, 5'd1,  2'b11, 1'b1, 32'h8000_0000);
    issue(32'hC000_0000, 5'd16, 2'b10, 1'b1, 32'hFFFF_C000);

    issue(32'h0000_00F0, 5'd4, 2'b00, 1'b0, 32'h0000_0F00);
    idle();
    check("hold_q", q, 32'h0000_0F00);
    check("hold_out_valid", {31'b0, out_valid}, 32'h0);
    idle();
    check("hold_q_2", q, 32'h0000_0F00);

    rst_n = 1'b0; in_valid = 1'b1; d = 32'hDEAD_BEEF; shift_amt = 5'd1; op = 2'b01; dir = 1'b0;
    @(posedge clk); #1;
    check("reset_valid_q", q, 32'h0);
    check("reset_valid_out_valid", {31'b0, out_valid}, 32'h0);
    rst_n = 1'b1;
    issue(32'h0000_0010, 5'd2, 2'b01, 1'b0, 32'h0000_0004);

    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 7) == 0) idle();
      else begin
        a = $urandom; n = 5'($urandom); o = 2'($urandom); r = 1'($urandom);
        issue(a, n, o, r, ref_model(a, n, o, r));
      end
    end

    idle(); idle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
